s2_pipe: RTL

S2_PIPE -- requirements
Module: s2_pipe

---
 rtl/s2_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/s2_pipe.sv
// Select-decoded input feeding a DEPTH-stage valid/ready register pipeline.
// Every stage advances whenever any stage at or after it is empty or the sink is draining.
module s2_pipe #(
    parameter int N     = 8,
    parameter int DEPTH = 2,
    parameter int MODE  = 0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    input  logic         A1,
    input  logic         B1,
    input  logic         A0,
    input  logic         B0,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         s1;
    logic         s0;
    logic [N-1:0] sel;

    logic [N-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdy;

    always_comb begin
        if (MODE == 0) begin
            s1 = A1 | B1;
            s0 = A0 & B0;
        end else begin
            s1 = A1 & B1;
            s0 = A0 | B0;
        end
        case ({s1, s0})
            2'b00:   sel = D0;
            2'b01:   sel = D1;
            2'b10:   sel = D2;
            default: sel = D3;
        endcase
    end

    // The backward ready chain is flattened: stage k is ready when the sink
    // accepts or any stage from k to the end holds a bubble.
    always_comb begin
        rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            logic r;
            r = out_ready;
            for (int unsigned j = k; j < DEPTH; j++) begin
                r = r | ~valid_q[j];
            end
            rdy[k] = r;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                data_q[0]  <= sel;
                valid_q[0] <= in_valid;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out       = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule
